// File: rtl/axi_rd_ch_ctrl.sv
`default_nettype none
// =============================================================================
// axi_rd_ch_ctrl : AXI4 AR/R channel controller between a split burst FIFO and
// a read slave. Define RD_RLAST_CHECK_EN to enable rlast cross-checking.
// Revision 1.0
// =============================================================================
module axi_rd_ch_ctrl #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 256,
   parameter int ID_WIDTH   = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [ADDR_WIDTH-1:0] mo_ar_addr,
   input  logic [8:0]            mo_ar_len,
   input  logic                  mo_ar_valid,
   output logic                  mo_ar_ready,
   input  logic [8:0]            mo_r_len,
   input  logic                  mo_fifo_empty,
   output logic                  mo_r_done,
   output logic [ADDR_WIDTH-1:0] araddr,
   output logic [7:0]            arlen,
   output logic [2:0]            arsize,
   output logic [1:0]            arburst,
   output logic [ID_WIDTH-1:0]   arid,
   output logic                  arvalid,
   input  logic                  arready,
   input  logic [DATA_WIDTH-1:0] rdata,
   input  logic [1:0]            rresp,
   input  logic                  rlast,
   input  logic                  rvalid,
   output logic                  rready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  err_resp,
   output logic                  err_rlast
);
   localparam logic [0:0] AR_IDLE = 1'b0;
   localparam logic [0:0] AR_SEND = 1'b1;
   localparam logic [2:0] AR_SIZE = 3'($clog2(DATA_WIDTH / 8));

   logic [0:0]            ar_state_q, ar_state_d;
   logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic [7:0]            arlen_q, arlen_d;
   logic [8:0]            outstanding_q, outstanding_d;
   logic [8:0]            beat_q, beat_d;
   logic                  err_resp_q, err_resp_d;
   logic                  ar_load, ar_hs, r_open, r_hs, final_beat;

   // A completed handshake in AR_SEND may immediately reload the next entry.
   always_comb begin
      ar_state_d = ar_state_q;
      ar_load    = 1'b0;
      case (ar_state_q)
         AR_IDLE: begin
            if (mo_ar_valid) begin
               ar_load    = 1'b1;
               ar_state_d = AR_SEND;
            end
         end
         AR_SEND: begin
            if (arready) begin
               if (mo_ar_valid) ar_load    = 1'b1;
               else             ar_state_d = AR_IDLE;
            end
         end
         default: ar_state_d = AR_IDLE;
      endcase
      araddr_d = ar_load ? mo_ar_addr : araddr_q;
      arlen_d  = ar_load ? (mo_ar_len[7:0] - 8'd1) : arlen_q;
   end

   assign mo_ar_ready = rstn & ar_load;
   assign arvalid     = (ar_state_q == AR_SEND);
   assign ar_hs       = arvalid & arready;
   assign araddr      = araddr_q;
   assign arlen       = arlen_q;
   assign arsize      = AR_SIZE;
   assign arburst     = 2'b01;
   assign arid        = '0;

   // R beats only flow once an AR is in flight and the FIFO knows the burst length.
   assign r_open     = rstn & (outstanding_q != 9'd0) & ~mo_fifo_empty;
   assign rready     = r_open & out_ready;
   assign out_valid  = r_open & rvalid;
   assign out_data   = rdata;
   assign r_hs       = rvalid & rready;
   assign final_beat = r_hs & (beat_q == (mo_r_len - 9'd1));
   assign out_last   = final_beat;
   assign mo_r_done  = final_beat;
   assign err_resp   = err_resp_q;

   always_comb begin
      outstanding_d = outstanding_q;
      if (ar_hs && !final_beat)      outstanding_d = outstanding_q + 9'd1;
      else if (!ar_hs && final_beat) outstanding_d = outstanding_q - 9'd1;
      beat_d = beat_q;
      if (final_beat) beat_d = 9'd0;
      else if (r_hs)  beat_d = beat_q + 9'd1;
      err_resp_d = err_resp_q | (r_hs & (rresp != 2'b00));
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         ar_state_q    <= AR_IDLE;
         araddr_q      <= '0;
         arlen_q       <= 8'd0;
         outstanding_q <= 9'd0;
         beat_q        <= 9'd0;
         err_resp_q    <= 1'b0;
      end else begin
         ar_state_q    <= ar_state_d;
         araddr_q      <= araddr_d;
         arlen_q       <= arlen_d;
         outstanding_q <= outstanding_d;
         beat_q        <= beat_d;
         err_resp_q    <= err_resp_d;
      end
   end

`ifdef RD_RLAST_CHECK_EN
   logic err_rlast_q, err_rlast_d;
   logic unused_len_msb;

   assign unused_len_msb = mo_ar_len[8];
   assign err_rlast_d    = err_rlast_q | (r_hs & (rlast != final_beat));
   assign err_rlast      = err_rlast_q;

   always_ff @(posedge clk) begin
      if (!rstn) err_rlast_q <= 1'b0;
      else       err_rlast_q <= err_rlast_d;
   end
`else
   logic unused_inputs;

   assign unused_inputs = mo_ar_len[8] ^ rlast;
   assign err_rlast     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_ch_ctrl.sv
`default_nettype none
// tb_axi_rd_ch_ctrl : directed bench with a small split-FIFO and AXI read-slave
// environment; expected values are hand-computed per scenario.
module tb_axi_rd_ch_ctrl;
   localparam int AW = 64;
   localparam int DW = 256;
   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          rstn;
   logic [AW-1:0] mo_ar_addr;
   logic [8:0]    mo_ar_len;
   logic          mo_ar_valid, mo_ar_ready;
   logic [8:0]    mo_r_len;
   logic          mo_fifo_empty, mo_r_done;
   logic [AW-1:0] araddr;
   logic [7:0]    arlen;
   logic [2:0]    arsize;
   logic [1:0]    arburst;
   logic [IW-1:0] arid;
   logic          arvalid, arready;
   logic [DW-1:0] rdata;
   logic [1:0]    rresp;
   logic          rlast, rvalid, rready;
   logic [DW-1:0] out_data;
   logic          out_last, out_valid, out_ready;
   logic          err_resp, err_rlast;

   always #5 clk = ~clk;

   axi_rd_ch_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
      .clk(clk), .rstn(rstn),
      .mo_ar_addr(mo_ar_addr), .mo_ar_len(mo_ar_len), .mo_ar_valid(mo_ar_valid),
      .mo_ar_ready(mo_ar_ready), .mo_r_len(mo_r_len), .mo_fifo_empty(mo_fifo_empty),
      .mo_r_done(mo_r_done), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arid(arid), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
      .out_ready(out_ready), .err_resp(err_resp), .err_rlast(err_rlast)
   );

   // split-FIFO model
   logic [AW-1:0] f_addr [16];
   int            f_len  [16];
   int            f_n, ar_ptr, r_ptr;
   // read-slave model
   int            s_q[$];
   int            s_beat;
   bit            ar_en, tog;
   int            bad_resp_beat, bad_last_beat;
   // records
   int            cyc, beats, arrdy_pulses, data_err, or_viol, first_beat_cyc, last_beat_cyc;
   int            done_at[$], last_at[$], ar_cyc[$], ar_len_seen[$];
   logic [AW-1:0] ar_addr_seen[$];
   logic          smp_ar_ready, smp_rready, smp_out_valid, smp_out_last, smp_done;
   int            n_chk, n_pass;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic clr();
      done_at.delete(); last_at.delete(); ar_cyc.delete();
      ar_addr_seen.delete(); ar_len_seen.delete();
      arrdy_pulses = 0; data_err = 0; or_viol = 0; beats = 0;
      first_beat_cyc = -1; last_beat_cyc = -1;
   endtask

   task automatic cycle();
      bit ar_hs, r_hs, took_ar, done;
      int len_s;
      mo_ar_valid   = (ar_ptr < f_n);
      mo_ar_addr    = mo_ar_valid ? f_addr[ar_ptr] : '0;
      mo_ar_len     = mo_ar_valid ? 9'(f_len[ar_ptr]) : 9'd1;
      mo_fifo_empty = (r_ptr >= f_n);
      mo_r_len      = mo_fifo_empty ? 9'd1 : 9'(f_len[r_ptr]);
      arready       = ar_en;
      out_ready     = tog ? ((cyc % 2) == 0) : 1'b1;
      rvalid        = (s_q.size() > 0);
      rdata         = DW'(beats + 1);
      rresp         = (bad_resp_beat == beats + 1) ? 2'b10 : 2'b00;
      rlast         = rvalid && ((s_beat == s_q[0] - 1) || (bad_last_beat == beats + 1));
      @(negedge clk);
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      took_ar = mo_ar_ready;
      done    = mo_r_done;
      len_s   = int'(arlen) + 1;
      smp_ar_ready = mo_ar_ready; smp_rready = rready; smp_out_valid = out_valid;
      smp_out_last = out_last;    smp_done   = mo_r_done;
      if (mo_ar_ready) arrdy_pulses++;
      if ((!out_ready && rready) || (rvalid && (rready !== out_ready))) or_viol++;
      if (r_hs) begin
         if (!out_valid || out_data !== DW'(beats + 1)) data_err++;
         if (first_beat_cyc < 0) first_beat_cyc = cyc;
         last_beat_cyc = cyc;
      end
      if (out_last)  last_at.push_back(beats + 1);
      if (mo_r_done) done_at.push_back(beats + 1);
      if (ar_hs) begin
         ar_cyc.push_back(cyc); ar_addr_seen.push_back(araddr); ar_len_seen.push_back(int'(arlen));
      end
      @(posedge clk); #1;
      cyc++;
      if (took_ar) ar_ptr++;
      if (ar_hs) s_q.push_back(len_s);
      if (r_hs) begin
         beats++; s_beat++;
         if (s_beat == s_q[0]) begin void'(s_q.pop_front()); s_beat = 0; end
      end
      if (done) r_ptr++;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      f_n = 0; ar_ptr = 0; r_ptr = 0; s_q.delete(); s_beat = 0;
      ar_en = 1; tog = 0; bad_resp_beat = 0; bad_last_beat = 0;
      cycle(); cycle();
      clr();
      rstn = 1'b1;
   endtask

   task automatic push(input logic [AW-1:0] a, input int l);
      f_addr[f_n] = a; f_len[f_n] = l; f_n++;
   endtask

   task automatic run_until(input int n, input int budget);
      int k = 0;
      while (done_at.size() < n && k < budget) begin cycle(); k++; end
      chk("done_count", done_at.size(), n);
   endtask

   task automatic wait_beats(input int n, input int budget);
      int k = 0;
      while (beats < n && k < budget) begin cycle(); k++; end
      chk("beats_reached", beats, n);
   endtask

   initial begin
      int hold_ok;
      n_chk = 0; n_pass = 0; cyc = 0;
      rstn = 1'b0; ar_en = 1; tog = 0; bad_resp_beat = 0; bad_last_beat = 0;
      f_n = 0; ar_ptr = 0; r_ptr = 0; s_beat = 0;
      clr();
      // reset with a pending FIFO entry: nothing may be consumed
      push(64'h1000, 4);
      cycle(); cycle();
      chk("rst_mo_ar_ready", smp_ar_ready, 0);
      chk("rst_rready", smp_rready, 0);
      chk("rst_out_valid", smp_out_valid, 0);
      chk("rst_out_last", smp_out_last, 0);
      chk("rst_done", smp_done, 0);
      chk("rst_arvalid", arvalid, 0);
      chk("rst_araddr", araddr, 0);
      chk("rst_arlen", arlen, 0);
      chk("rst_err_resp", err_resp, 0);
      chk("rst_err_rlast", err_rlast, 0);
      chk("rst_ar_ptr", ar_ptr, 0);
      clr();
      rstn = 1'b1;

      // single len-4 burst
      run_until(1, 50);
      chk("a_araddr", ar_addr_seen[0], 64'h1000);
      chk("a_arlen", ar_len_seen[0], 3);
      chk("a_arsize", arsize, 5);
      chk("a_arburst", arburst, 1);
      chk("a_arid", arid, 0);
      chk("a_beats", beats, 4);
      chk("a_last_cnt", last_at.size(), 1);
      chk("a_last_beat", last_at[0], 4);
      chk("a_done_beat", done_at[0], 4);
      chk("a_data", data_err, 0);

      // arready held low
      do_reset();
      push(64'h1000, 1);
      ar_en = 0;
      cycle();
      hold_ok = 0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         if (arvalid === 1'b1 && araddr === 64'h1000) hold_ok++;
      end
      chk("b_hold", hold_ok, 5);
      chk("b_no_hs", ar_cyc.size(), 0);
      ar_en = 1;
      run_until(1, 20);
      chk("b_ar_ready_pulses", arrdy_pulses, 1);
      chk("b_araddr", ar_addr_seen[0], 64'h1000);

      // three queued bursts 1, 256, 2
      do_reset();
      push(64'h2000, 1); push(64'h3000, 256); push(64'h4000, 2);
      run_until(3, 400);
      chk("c_ar_count", ar_cyc.size(), 3);
      chk("c_ar_gap1", ar_cyc[1] - ar_cyc[0], 1);
      chk("c_ar_gap2", ar_cyc[2] - ar_cyc[1], 1);
      chk("c_arlen256", ar_len_seen[1], 255);
      chk("c_done0", done_at[0], 1);
      chk("c_done1", done_at[1], 257);
      chk("c_done2", done_at[2], 259);
      chk("c_r_span", last_beat_cyc - first_beat_cyc, 258);
      chk("c_data", data_err, 0);
      chk("c_err_rlast", err_rlast, 0);
      chk("c_err_resp", err_resp, 0);

      // out_ready toggling
      do_reset();
      push(64'h6000, 8);
      tog = 1;
      run_until(1, 60);
      chk("d_beats", beats, 8);
      chk("d_data", data_err, 0);
      chk("d_rready_mirror", or_viol, 0);
      chk("d_done_beat", done_at[0], 8);
      tog = 0;

      // error response and early rlast
      do_reset();
      push(64'h7000, 4);
      bad_resp_beat = 2; bad_last_beat = 3;
      wait_beats(1, 20);
      chk("e_err_before", err_resp, 0);
      wait_beats(2, 20);
      chk("e_err_set", err_resp, 1);
      run_until(1, 20);
      cycle(); cycle(); cycle();
      chk("e_err_sticky", err_resp, 1);
      chk("e_beats", beats, 4);
      chk("e_done_beat", done_at[0], 4);
`ifdef RD_RLAST_CHECK_EN
      chk("e_err_rlast", err_rlast, 1);
`else
      chk("e_err_rlast", err_rlast, 0);
`endif
      do_reset();
      chk("e_err_clr", err_resp, 0);
      chk("e_rlast_clr", err_rlast, 0);

      // reset mid-burst, then a fresh len-2 burst
      push(64'h5000, 4);
      wait_beats(2, 20);
      rstn = 1'b0;
      cycle();
      chk("f_rready", smp_rready, 0);
      chk("f_out_valid", smp_out_valid, 0);
      chk("f_done", smp_done, 0);
      chk("f_arvalid", arvalid, 0);
      chk("f_araddr", araddr, 0);
      chk("f_arlen", arlen, 0);
      do_reset();
      push(64'h8000, 2);
      run_until(1, 20);
      chk("f_new_done_beat", done_at[0], 2);
      chk("f_new_beats", beats, 2);
      chk("f_new_data", data_err, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
`default_nettype wire
